// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin front-end for a single-port 256x4 SRAM macro.
// Commands and read responses are fully pipelined; reads return 2 clocks after acceptance.
module sram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_cs,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_any_grant;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          r_prio_b;
    logic          r_mem_cs;
    logic          r_mem_write;
    logic          r_mem_read;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_tag_vld_p0;
    logic          r_tag_port_p0;
    logic          r_tag_vld_p1;
    logic          r_tag_port_p1;
    logic          r_a_rvalid;
    logic [DW-1:0] r_a_rdata;
    logic          r_b_rvalid;
    logic [DW-1:0] r_b_rdata;

    // r_prio_b names the port that wins a tie; a lone requester always wins
    always_comb begin
        w_grant_a   = a_valid & (~b_valid | ~r_prio_b);
        w_grant_b   = b_valid & ~w_grant_a;
        w_any_grant = w_grant_a | w_grant_b;
        w_sel_we    = w_grant_b ? b_we    : a_we;
        w_sel_addr  = w_grant_b ? b_addr  : a_addr;
        w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (w_grant_a) begin
            r_prio_b <= 1'b1;
        end else if (w_grant_b) begin
            r_prio_b <= 1'b0;
        end
    end

    // Stage p0: registered SRAM command plus the tag of the read just issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cs      <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_tag_vld_p0  <= 1'b0;
            r_tag_port_p0 <= 1'b0;
        end else if (w_any_grant) begin
            r_mem_cs      <= 1'b1;
            r_mem_write   <= w_sel_we;
            r_mem_read    <= ~w_sel_we;
            r_mem_addr    <= w_sel_addr;
            r_mem_wdata   <= w_sel_we ? w_sel_wdata : '0;
            r_tag_vld_p0  <= ~w_sel_we;
            r_tag_port_p0 <= w_grant_b;
        end else begin
            r_mem_cs      <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_tag_vld_p0  <= 1'b0;
        end
    end

    // Stage p1: tag waits while the SRAM performs the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld_p1  <= 1'b0;
            r_tag_port_p1 <= 1'b0;
        end else begin
            r_tag_vld_p1  <= r_tag_vld_p0;
            r_tag_port_p1 <= r_tag_port_p0;
        end
    end

    // Response stage: steer SRAM output to the tagged port; the other port holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= r_tag_vld_p1 & ~r_tag_port_p1;
            r_b_rvalid <= r_tag_vld_p1 & r_tag_port_p1;
            if (r_tag_vld_p1 && !r_tag_port_p1) begin
                r_a_rdata <= mem_rdata;
            end
            if (r_tag_vld_p1 && r_tag_port_p1) begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

    assign mem_cs    = r_mem_cs;
    assign mem_write = r_mem_write;
    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign a_rvalid  = r_a_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rvalid  = r_b_rvalid;
    assign b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM and a memory/arbitration model.
module tb_sram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_ready, a_we, a_rvalid;
    logic [7:0] a_addr;
    logic [3:0] a_wdata, a_rdata;
    logic       b_valid, b_ready, b_we, b_rvalid;
    logic [7:0] b_addr;
    logic [3:0] b_wdata, b_rdata;
    logic       mem_cs, mem_write, mem_read;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sram_port_arbiter #(.AW(8), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_cs(mem_cs), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro: registered read, output 0 when not reading
    logic [3:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_cs && mem_write) sram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_cs && mem_read) ? sram[mem_addr] : 4'h0;
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] data;
        int         due;
    } rsp_t;

    rsp_t       qa[$];
    rsp_t       qb[$];
    logic [3:0] mdl_mem [0:255];
    bit         mdl_prio_b;
    bit         ga, gb;
    logic       exp_cs, exp_wr, exp_rd;
    logic [7:0] exp_addr;
    logic [3:0] exp_wdata;
    logic [3:0] last_a, last_b;

    // Model: predict grant, command and read result at each negedge for the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            mdl_prio_b = 1'b0;
            exp_cs = 0; exp_wr = 0; exp_rd = 0; exp_addr = 0; exp_wdata = 0;
            chk({mem_cs, mem_write, mem_read} == 3'b000, "rst_mem_ctl", {mem_cs, mem_write, mem_read}, 0);
            chk(mem_addr == 8'h0 && mem_wdata == 4'h0, "rst_mem_data", {mem_addr, mem_wdata}, 0);
            chk({a_rvalid, b_rvalid} == 2'b00, "rst_rvalid", {a_rvalid, b_rvalid}, 0);
            chk(a_rdata == 4'h0 && b_rdata == 4'h0, "rst_rdata", {a_rdata, b_rdata}, 0);
        end else begin
            chk(mem_cs == exp_cs, "mem_cs", mem_cs, exp_cs);
            chk(mem_write == exp_wr, "mem_write", mem_write, exp_wr);
            chk(mem_read == exp_rd, "mem_read", mem_read, exp_rd);
            chk(mem_addr == exp_addr, "mem_addr", mem_addr, exp_addr);
            chk(mem_wdata == exp_wdata, "mem_wdata", mem_wdata, exp_wdata);
            ga = a_valid && (!b_valid || !mdl_prio_b);
            gb = b_valid && !ga;
            chk(a_ready == ga, "a_ready", a_ready, ga);
            chk(b_ready == gb, "b_ready", b_ready, gb);
            if (ga || gb) begin
                exp_cs    = 1;
                exp_wr    = ga ? a_we : b_we;
                exp_rd    = !exp_wr;
                exp_addr  = ga ? a_addr : b_addr;
                exp_wdata = exp_wr ? (ga ? a_wdata : b_wdata) : 4'h0;
                if (exp_wr) mdl_mem[exp_addr] = exp_wdata;
                else if (ga) qa.push_back('{data: mdl_mem[exp_addr], due: cyc + 3});
                else qb.push_back('{data: mdl_mem[exp_addr], due: cyc + 3});
                mdl_prio_b = ga;
            end else begin
                exp_cs = 0; exp_wr = 0; exp_rd = 0;
            end
        end
    end

    // Monitor: pop expected responses when the DUT presents rvalid
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = 4'h0;
            last_b = 4'h0;
        end else begin
            if (a_rvalid) begin
                if (qa.size() == 0) chk(0, "a_rvalid_unexpected", 1, 0);
                else begin
                    chk(cyc == qa[0].due, "a_latency", cyc, qa[0].due);
                    last_a = qa[0].data;
                    void'(qa.pop_front());
                end
            end else if (qa.size() != 0 && qa[0].due <= cyc) begin
                chk(0, "a_rvalid_missing", 0, 1);
                void'(qa.pop_front());
            end
            chk(a_rdata == last_a, "a_rdata", a_rdata, last_a);
            if (b_rvalid) begin
                if (qb.size() == 0) chk(0, "b_rvalid_unexpected", 1, 0);
                else begin
                    chk(cyc == qb[0].due, "b_latency", cyc, qb[0].due);
                    last_b = qb[0].data;
                    void'(qb.pop_front());
                end
            end else if (qb.size() != 0 && qb[0].due <= cyc) begin
                chk(0, "b_rvalid_missing", 0, 1);
                void'(qb.pop_front());
            end
            chk(b_rdata == last_b, "b_rdata", b_rdata, last_b);
        end
    end

    task automatic drive(input logic av, input logic awe, input logic [7:0] aad, input logic [3:0] awd,
                         input logic bv, input logic bwe, input logic [7:0] bad, input logic [3:0] bwd);
        a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 8'h0, 4'h0, 0, 0, 8'h0, 4'h0);
    endtask

    initial begin
        logic [3:0] d;
        rst_n = 1'b0;
        a_valid = 1; a_we = 0; a_addr = 8'h33; a_wdata = 4'h0;
        b_valid = 0; b_we = 0; b_addr = 8'h0;  b_wdata = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk(a_ready == 1'b1, "rst_comb_a_ready", a_ready, 1);
        chk(b_ready == 1'b0, "rst_comb_b_ready", b_ready, 0);
        a_valid = 0;
        rst_n = 1'b1;

        // Preload addresses 0..31 through both ports
        for (int i = 0; i < 32; i++) begin
            d = 4'(i * 5 + 3);
            if (i % 2 == 0) drive(1, 1, 8'(i), d, 0, 0, 8'h0, 4'h0);
            else            drive(0, 0, 8'h0, 4'h0, 1, 1, 8'(i), d);
        end
        idle(2);

        // Single port write then read-after-write hazard
        drive(1, 1, 8'h10, 4'hA, 0, 0, 8'h0, 4'h0);
        drive(1, 0, 8'h10, 4'h0, 0, 0, 8'h0, 4'h0);
        idle(4);

        // Contention on reads of 0x01 / 0x02
        drive(1, 1, 8'h01, 4'h1, 0, 0, 8'h0, 4'h0);
        drive(0, 0, 8'h0, 4'h0, 1, 1, 8'h02, 4'h2);
        for (int i = 0; i < 4; i++) drive(1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0);
        idle(4);

        // Pointer after a lone B grant
        drive(0, 0, 8'h0, 4'h0, 1, 0, 8'h05, 4'h0);
        drive(1, 0, 8'h06, 4'h0, 1, 0, 8'h07, 4'h0);
        idle(4);

        // Back-to-back reads 0..7
        for (int i = 0; i < 8; i++) drive(1, 0, 8'(i), 4'h0, 0, 0, 8'h0, 4'h0);
        idle(4);

        // Reset while a read is in flight
        drive(1, 0, 8'h03, 4'h0, 0, 0, 8'h0, 4'h0);
        a_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Randomized traffic over a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 4'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 4'($urandom));
        end
        idle(5);

        chk(qa.size() == 0, "a_queue_drained", qa.size(), 0);
        chk(qb.size() == 0, "b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
